// File: rtl/pkt_fifo.sv
// pkt_fifo: packet buffer for the SPI register map.
// Software writes a length, then that many data words; the committed packet
// is drained either by the register read strobe (rd_en -> data_out) or by a
// first-word-fall-through valid/ready stream. Misuse sets sticky error bits,
// and flush returns the block to a clean IDLE without a reset.
module pkt_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int LEN_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       length_wr_en,
    input  logic [LEN_W-1:0]           length_in,
    input  logic                       length_rd_en,
    output logic [LEN_W-1:0]           length_out,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_last,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       read_complete,
    output logic [2:0]                 err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_LEN   = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LEN_W-1:0]  len;
    // words written so far while in FILL, words still to drain while in READY
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_inc;
    logic [LVL_W-1:0]  level_next;

    logic len_ok;
    logic push;
    logic rd_pop;
    logic stream_pop;
    logic pop;
    logic last_pop;

    // flush wins over every strobe, so all qualified actions are gated by it
    assign len_ok     = (length_in != '0) && (length_in <= DEPTH_LEN);
    assign push       = !flush && (state == FILL) && wr_en;
    assign rd_pop     = !flush && (state == READY) && rd_en;
    assign stream_pop = !flush && m_valid && m_ready;
    assign pop        = rd_pop || stream_pop;
    assign last_pop   = pop && (cnt == ONE_LEN);
    assign cnt_inc    = cnt + ONE_LEN;

    // the register read port has priority over the stream, so the stream
    // head is withdrawn for the cycle in which rd_en is asserted
    assign m_valid = (state == READY) && !rd_en;
    assign m_data  = mem[rd_ptr];
    assign m_last  = m_valid && (cnt == ONE_LEN);

    // next occupancy; push and pop live in different states and never coincide
    always_comb begin
        level_next = level;
        if (push) begin
            level_next = level + LVL_W'(1);
        end else if (pop) begin
            level_next = level - LVL_W'(1);
        end
    end

    // storage array: written only by accepted pushes, never reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // packet FSM with length latch and the shared fill/remaining counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            len   <= '0;
            cnt   <= '0;
        end else if (flush) begin
            state <= IDLE;
            len   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (length_wr_en && len_ok) begin
                        len   <= length_in;
                        cnt   <= '0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (push) begin
                        if (cnt_inc == len) begin
                            // switch the counter over to words remaining
                            cnt   <= len;
                            state <= READY;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                READY: begin
                    if (pop) begin
                        cnt <= cnt - ONE_LEN;
                        if (cnt == ONE_LEN) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // pointers and registered occupancy flags; pointers wrap modulo DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next;
            full  <= (level_next == DEPTH_LVL);
            empty <= (level_next == '0);
        end
    end

    // register-port read data, length readback and completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out      <= '0;
            length_out    <= '0;
            read_complete <= 1'b0;
        end else if (flush) begin
            read_complete <= 1'b0;
        end else begin
            read_complete <= last_pop;
            if (rd_pop) begin
                data_out <= mem[rd_ptr];
            end
            if (length_rd_en) begin
                length_out <= (state == IDLE) ? '0 : cnt;
            end
        end
    end

    // sticky misuse flags {len_err, wr_err, rd_err}, cleared only by flush/reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 3'b000;
        end else if (flush) begin
            err <= 3'b000;
        end else begin
            if (length_wr_en && ((state != IDLE) || !len_ok)) begin
                err[2] <= 1'b1;
            end
            if (wr_en && (state != FILL)) begin
                err[1] <= 1'b1;
            end
            if (rd_en && (state != READY)) begin
                err[0] <= 1'b1;
            end
        end
    end

endmodule
